// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: follows the one-hot vehicle semaphore state,
// serves latched button requests at vehicle RED entry, and latches a fault on illegal codes.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 30,
  parameter int FLASH_CYCLES = 12,
  parameter int FLASH_HALF   = 2,
  parameter int CNT_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       state_in,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_wait,
  output logic [CNT_W-1:0] countdown,
  output logic             ped_abort,
  output logic             fault
);

  localparam logic [4:0] VS_OFF    = 5'b00001;
  localparam logic [4:0] VS_RED    = 5'b00010;
  localparam logic [4:0] VS_RED_YE = 5'b00100;
  localparam logic [4:0] VS_GREEN  = 5'b01000;
  localparam logic [4:0] VS_YELLOW = 5'b10000;

  localparam int              BW         = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    ST_DARK, ST_DONT_WALK, ST_WALK, ST_FLASH, ST_FAULT
  } ped_state_e;

  ped_state_e        state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              blink_q, blink_d;
  logic              req_q, req_d;
  logic              abort_q, abort_d;
  logic [4:0]        prev_state_q;
  logic              btn_q;
  logic              illegal_q;

  logic legal, press, red_entry, fault_trig;

  assign legal = (state_in == VS_OFF) || (state_in == VS_RED) || (state_in == VS_RED_YE) ||
                 (state_in == VS_GREEN) || (state_in == VS_YELLOW);
  assign press      = ped_button & ~btn_q;
  assign red_entry  = (state_in == VS_RED) && (prev_state_q != VS_RED);
  assign fault_trig = ~legal & illegal_q;

  // NOTE: every register here, including the edge-detect history, takes the async reset;
  // a missed reset on prev_state_q would fake a RED entry right after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_DARK;
      timer_q      <= '0;
      bcnt_q       <= '0;
      blink_q      <= 1'b1;
      req_q        <= 1'b0;
      abort_q      <= 1'b0;
      prev_state_q <= VS_OFF;
      btn_q        <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q      <= state_d;
      timer_q      <= timer_d;
      bcnt_q       <= bcnt_d;
      blink_q      <= blink_d;
      req_q        <= req_d;
      abort_q      <= abort_d;
      prev_state_q <= state_in;
      btn_q        <= ped_button;
      illegal_q    <= ~legal;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    req_d   = req_q;
    abort_d = 1'b0;

    // Blink phase runs while flashing or faulted; transitions below may re-seed it.
    if (state_q == ST_FLASH || state_q == ST_FAULT) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
    if ((state_q == ST_WALK || state_q == ST_FLASH) && timer_q != '0)
      timer_d = timer_q - CNT_W'(1);
    if (state_q == ST_DONT_WALK && press)
      req_d = 1'b1;

    if (fault_trig && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
      timer_d = '0;
      req_d   = 1'b0;
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        ST_DARK: begin
          if (legal && state_in != VS_OFF) state_d = ST_DONT_WALK;
        end
        ST_DONT_WALK: begin
          if (state_in == VS_OFF) begin
            state_d = ST_DARK;
            req_d   = 1'b0;
          end else if (red_entry && req_q) begin
            state_d = ST_WALK;
            timer_d = CNT_W'(WALK_CYCLES - 1);
            req_d   = 1'b0;
          end
        end
        ST_WALK, ST_FLASH: begin
          if (state_in == VS_OFF) begin
            state_d = ST_DARK;
            timer_d = '0;
          end else if (legal && state_in != VS_RED) begin
            state_d = ST_DONT_WALK;
            timer_d = '0;
            abort_d = 1'b1;
          end else if (timer_q == '0) begin
            if (state_q == ST_WALK) begin
              state_d = ST_FLASH;
              timer_d = CNT_W'(FLASH_CYCLES - 1);
              blink_d = 1'b1;
              bcnt_d  = '0;
            end else begin
              state_d = ST_DONT_WALK;
            end
          end
        end
        ST_FAULT: ;
        default: state_d = ST_FAULT;
      endcase
    end
  end

  always_comb begin
    walk      = (state_q == ST_WALK);
    dont_walk = (state_q == ST_DONT_WALK) ||
                ((state_q == ST_FLASH || state_q == ST_FAULT) && blink_q);
    ped_wait  = req_q;
    ped_abort = abort_q;
    fault     = (state_q == ST_FAULT);
    case (state_q)
      ST_WALK:  countdown = timer_q + CNT_W'(FLASH_CYCLES + 1);
      ST_FLASH: countdown = timer_q + CNT_W'(1);
      default:  countdown = '0;
    endcase
  end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: directed scenarios plus randomized vehicle/button traffic,
// all checked against an elapsed-time model of the pedestrian phases.
module tb_ped_signal_ctrl;

  localparam int W  = 30;
  localparam int F  = 12;
  localparam int FH = 2;
  localparam int CW = 7;

  localparam logic [4:0] OFF = 5'b00001;
  localparam logic [4:0] RED = 5'b00010;
  localparam logic [4:0] RY  = 5'b00100;
  localparam logic [4:0] GRN = 5'b01000;
  localparam logic [4:0] YEL = 5'b10000;

  localparam int M_DARK = 0;
  localparam int M_DW   = 1;
  localparam int M_PH   = 2;
  localparam int M_FLT  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    state_in = OFF;
  logic          ped_button = 1'b0;
  logic          walk, dont_walk, ped_wait, ped_abort, fault;
  logic [CW-1:0] countdown;

  ped_signal_ctrl #(.WALK_CYCLES(W), .FLASH_CYCLES(F), .FLASH_HALF(FH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .ped_button(ped_button),
    .walk(walk), .dont_walk(dont_walk), .ped_wait(ped_wait), .countdown(countdown),
    .ped_abort(ped_abort), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the pedestrian phase is tracked by its start cycle, not a timer.
  int         m_mode;
  int         ph_start, flt_start;
  bit         m_req, m_abort, m_prev_illegal, m_btn;
  logic [4:0] m_prev;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_DARK;
    m_req = 0; m_abort = 0; m_prev_illegal = 0; m_btn = 0;
    m_prev = OFF;
  endtask

  task automatic model_step(input logic [4:0] vin, input bit btn);
    bit legal, press, red_entry;
    int n;
    n         = cyc;
    legal     = ($countones(vin) == 1);
    press     = btn && !m_btn;
    red_entry = (vin == RED) && (m_prev != RED);
    cyc++;
    m_abort = 0;
    if (m_mode != M_FLT && !legal && m_prev_illegal) begin
      m_mode = M_FLT; flt_start = cyc; m_req = 0;
    end else begin
      case (m_mode)
        M_DARK: if (legal && vin != OFF) m_mode = M_DW;
        M_DW: begin
          if (vin == OFF) begin m_mode = M_DARK; m_req = 0; end
          else if (red_entry && m_req) begin m_mode = M_PH; ph_start = cyc; m_req = 0; end
          else if (press) m_req = 1;
        end
        M_PH: begin
          if (vin == OFF) m_mode = M_DARK;
          else if (legal && vin != RED) begin m_mode = M_DW; m_abort = 1; end
          else if (n - ph_start == W + F - 1) m_mode = M_DW;
        end
        default: ;
      endcase
    end
    m_prev = vin;
    m_prev_illegal = !legal;
    m_btn = btn;
  endtask

  task automatic compare_all();
    int e_walk, e_dw, e_cd, e_flt, e;
    e_walk = 0; e_dw = 0; e_cd = 0; e_flt = 0;
    case (m_mode)
      M_DW: e_dw = 1;
      M_PH: begin
        e = cyc - ph_start;
        if (e < W) e_walk = 1;
        else e_dw = (((e - W) / FH) % 2 == 0) ? 1 : 0;
        e_cd = W + F - e;
      end
      M_FLT: begin
        e_flt = 1;
        e_dw = (((cyc - flt_start) / FH) % 2 == 0) ? 1 : 0;
      end
      default: ;
    endcase
    check("walk", int'(walk), e_walk);
    check("dont_walk", int'(dont_walk), e_dw);
    check("ped_wait", int'(ped_wait), int'(m_req));
    check("countdown", int'(countdown), e_cd);
    check("ped_abort", int'(ped_abort), int'(m_abort));
    check("fault", int'(fault), e_flt);
  endtask

  task automatic tick(input logic [4:0] vin, input bit btn);
    state_in = vin;
    ped_button = btn;
    @(posedge clk);
    model_step(vin, btn);
    #1;
    compare_all();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".walk"}, int'(walk), 0);
    check({tag, ".dont_walk"}, int'(dont_walk), 0);
    check({tag, ".ped_wait"}, int'(ped_wait), 0);
    check({tag, ".countdown"}, int'(countdown), 0);
    check({tag, ".ped_abort"}, int'(ped_abort), 0);
    check({tag, ".fault"}, int'(fault), 0);
  endtask

  task automatic apply_reset();
    state_in = OFF;
    ped_button = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    model_reset();
    reset = 1;
  endtask

  task automatic random_episode(input int ncyc, input bit allow_illegal);
    int left, ph;
    logic [4:0] cur, vin;
    bit btn;
    apply_reset();
    left = 0; ph = 3; cur = OFF;
    repeat (3) tick(OFF, 0);
    for (int i = 0; i < ncyc; i++) begin
      if (left == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          cur = OFF; left = $urandom_range(1, 4);
        end else begin
          ph = (ph + 1) % 4;
          case (ph)
            0:       begin cur = RED; left = $urandom_range(20, 60); end
            1:       begin cur = RY;  left = $urandom_range(2, 4);   end
            2:       begin cur = GRN; left = $urandom_range(5, 25);  end
            default: begin cur = YEL; left = $urandom_range(2, 5);   end
          endcase
        end
      end
      left--;
      vin = cur;
      if (allow_illegal && $urandom_range(0, 199) < 3) vin = 5'($urandom_range(0, 31));
      btn = ($urandom_range(0, 5) == 0);
      tick(vin, btn);
    end
  endtask

  initial begin
    int nwalk;
    model_reset();

    // 1: reset, dark, then first RED lights DONT_WALK only
    apply_reset();
    repeat (10) tick(OFF, 0);
    check("t1_dark_dw", int'(dont_walk), 0);
    tick(RED, 0);
    check("t1_dw_on", int'(dont_walk), 1);
    check("t1_no_walk", int'(walk), 0);

    // 2: latched request served at the next RED entry, full walk/flash sequence
    repeat (3) tick(GRN, 0);
    tick(GRN, 1);
    check("t2_wait", int'(ped_wait), 1);
    tick(GRN, 0);
    repeat (3) tick(YEL, 0);
    for (int i = 0; i < 51; i++) begin
      tick(RED, 0);
      if (i == 0) begin
        check("t2_walk_on", int'(walk), 1);
        check("t2_cd42", int'(countdown), 42);
        check("t2_wait_clr", int'(ped_wait), 0);
      end
    end
    check("t2_end_dw", int'(dont_walk), 1);
    check("t2_end_cd", int'(countdown), 0);

    // 3: held button gives a single walk phase across two REDs
    repeat (2) tick(RY, 0);
    repeat (5) tick(GRN, 1);
    repeat (3) tick(YEL, 1);
    nwalk = 0;
    for (int i = 0; i < 51; i++) begin tick(RED, 1); nwalk += int'(walk); end
    check("t3_first_walk", nwalk, W);
    repeat (3) tick(RY, 1);
    repeat (5) tick(GRN, 1);
    repeat (3) tick(YEL, 1);
    nwalk = 0;
    for (int i = 0; i < 51; i++) begin tick(RED, 1); nwalk += int'(walk); end
    check("t3_second_walk", nwalk, 0);

    // 4: abort in the middle of WALK
    tick(GRN, 0);
    tick(GRN, 1);
    tick(GRN, 0);
    repeat (2) tick(YEL, 0);
    for (int i = 0; i < 23; i++) tick(RED, 0);
    check("t4_cd20", int'(countdown), 20);
    tick(RY, 0);
    check("t4_abort", int'(ped_abort), 1);
    check("t4_walk_off", int'(walk), 0);
    check("t4_cd0", int'(countdown), 0);
    tick(RY, 0);
    check("t4_abort_pulse", int'(ped_abort), 0);

    // 5: single glitch ignored, two illegal cycles latch a fault
    tick(GRN, 0);
    tick(5'b00011, 0);
    tick(GRN, 0);
    check("t5_glitch", int'(fault), 0);
    tick(5'b00000, 0);
    tick(5'b00000, 0);
    check("t5_fault", int'(fault), 1);
    repeat (3) tick(5'b00000, 0);
    repeat (6) tick(GRN, 1);
    check("t5_sticky", int'(fault), 1);

    // 6: asynchronous reset in the middle of FLASH
    apply_reset();
    tick(GRN, 0);
    tick(GRN, 1);
    tick(GRN, 0);
    for (int i = 0; i < 34; i++) tick(RED, 0);
    check("t6_in_flash", int'(countdown), 9);
    #2;
    reset = 0;
    #1;
    check_outputs_zero("t6_async");
    model_reset();
    state_in = RED;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    repeat (3) tick(RED, 0);
    check("t6_dw", int'(dont_walk), 1);
    check("t6_no_wait", int'(ped_wait), 0);

    // Randomized traffic against the model
    random_episode(2000, 0);
    random_episode(2000, 0);
    random_episode(1500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
